// File: rtl/shared_mem_frontend_if.sv
// Purpose: client, arbiter and memory-port signals of the shared memory frontend.
// Latency: none, wiring only.
// Backpressure: clients see c*_ready/stall_*; the arbiter sees req_*/grant_*.
interface shared_mem_frontend_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   // client 1
   logic              c1_valid;
   logic              c1_we;
   logic [ADDR_W-1:0] c1_addr;
   logic [DATA_W-1:0] c1_wdata;
   logic              c1_ready;
   logic              c1_rvalid;
   logic [DATA_W-1:0] c1_rdata;
   logic              stall_1;
   // client 2
   logic              c2_valid;
   logic              c2_we;
   logic [ADDR_W-1:0] c2_addr;
   logic [DATA_W-1:0] c2_wdata;
   logic              c2_ready;
   logic              c2_rvalid;
   logic [DATA_W-1:0] c2_rdata;
   logic              stall_2;
   // arbiter
   logic              req_1;
   logic              req_2;
   logic              grant_1;
   logic              grant_2;
   // shared memory port
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // frontend view
   modport slave (
      input  c1_valid, c1_we, c1_addr, c1_wdata,
      output c1_ready, c1_rvalid, c1_rdata, stall_1,
      input  c2_valid, c2_we, c2_addr, c2_wdata,
      output c2_ready, c2_rvalid, c2_rdata, stall_2,
      output req_1, req_2,
      input  grant_1, grant_2,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // environment view (clients, arbiter, memory)
   modport master (
      output c1_valid, c1_we, c1_addr, c1_wdata,
      input  c1_ready, c1_rvalid, c1_rdata, stall_1,
      output c2_valid, c2_we, c2_addr, c2_wdata,
      input  c2_ready, c2_rvalid, c2_rdata, stall_2,
      input  req_1, req_2,
      output grant_1, grant_2,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/shared_mem_frontend.sv
// Purpose: parks one request per client, requests the arbiter, issues on the shared port, returns responses.
// Latency: accept->req 1, grant->mem_en 0 (comb), mem_en->rvalid MEM_LAT; next accept one cycle after rvalid.
// Backpressure: a client's ready drops and stall rises from accept until its rvalid cycle ends.
module shared_mem_frontend #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1   // legal range 1..4
) (
   input logic               clk,
   input logic               reset,
   shared_mem_frontend_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      PEND   = 2'b01,
      ISSUED = 2'b10
   } slot_state_e;

   // Per-client view, index 0 = client 1, index 1 = client 2
   slot_state_e       state_q [2];
   slot_state_e       state_d [2];
   logic [1:0]        in_valid;
   logic [1:0]        in_we;
   logic [ADDR_W-1:0] in_addr  [2];
   logic [DATA_W-1:0] in_wdata [2];
   logic [1:0]        ready;
   logic [1:0]        accept;
   logic [1:0]        issue;
   logic [1:0]        resp;
   logic [1:0]        we_q;
   logic [ADDR_W-1:0] addr_q   [2];
   logic [DATA_W-1:0] wdata_q  [2];

   // One-hot owner tag per issued access, aged one stage per cycle
   logic [1:0]        tag_q [MEM_LAT];

   assign in_valid    = {bus.c2_valid, bus.c1_valid};
   assign in_we       = {bus.c2_we, bus.c1_we};
   assign in_addr[0]  = bus.c1_addr;
   assign in_addr[1]  = bus.c2_addr;
   assign in_wdata[0] = bus.c1_wdata;
   assign in_wdata[1] = bus.c2_wdata;

   assign ready[0]  = (state_q[0] == IDLE) && !reset;
   assign ready[1]  = (state_q[1] == IDLE) && !reset;
   assign accept    = ready & in_valid;

   // Client 1 wins a double grant; a grant to a non-pending slot is a stale
   // arbiter grant and is dropped, which may leave the port to the other slot.
   assign issue[0]  = (state_q[0] == PEND) && bus.grant_1 && !reset;
   assign issue[1]  = (state_q[1] == PEND) && bus.grant_2 && !issue[0] && !reset;

   // The oldest tag stage marks the cycle mem_rdata belongs to its owner.
   // Reset suppresses the response so in-flight data is discarded.
   assign resp[0]   = (state_q[0] == ISSUED) && tag_q[MEM_LAT-1][0] && !reset;
   assign resp[1]   = (state_q[1] == ISSUED) && tag_q[MEM_LAT-1][1] && !reset;

   // Slot state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q[0] <= IDLE;
         state_q[1] <= IDLE;
      end else begin
         state_q[0] <= state_d[0];
         state_q[1] <= state_d[1];
      end
   end

   // Slot next-state: park on accept, issue on grant, free on response
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            IDLE:    if (accept[i]) state_d[i] = PEND;
            PEND:    if (issue[i])  state_d[i] = ISSUED;
            ISSUED:  if (resp[i])   state_d[i] = IDLE;
            default: state_d[i] = IDLE;
         endcase
      end
   end

   // Latch the request payload when the slot accepts it
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q <= '0;
         for (int i = 0; i < 2; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (accept[i]) begin
               we_q[i]    <= in_we[i];
               addr_q[i]  <= in_addr[i];
               wdata_q[i] <= in_wdata[i];
            end
         end
      end
   end

   // Owner tag pipeline matching the fixed memory latency
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < MEM_LAT; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         tag_q[0] <= issue;
         for (int s = 1; s < MEM_LAT; s++) begin
            tag_q[s] <= tag_q[s-1];
         end
      end
   end

   // Shared port mux: at most one issuer per cycle, all-zero when idle
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (issue[0]) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = we_q[0];
         bus.mem_addr  = addr_q[0];
         bus.mem_wdata = wdata_q[0];
      end else if (issue[1]) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = we_q[1];
         bus.mem_addr  = addr_q[1];
         bus.mem_wdata = wdata_q[1];
      end
   end

   assign bus.req_1     = (state_q[0] == PEND);
   assign bus.req_2     = (state_q[1] == PEND);
   assign bus.stall_1   = (state_q[0] != IDLE);
   assign bus.stall_2   = (state_q[1] != IDLE);
   assign bus.c1_ready  = ready[0];
   assign bus.c2_ready  = ready[1];
   assign bus.c1_rvalid = resp[0];
   assign bus.c2_rvalid = resp[1];
   // Writes complete with zero data
   assign bus.c1_rdata  = (resp[0] && !we_q[0]) ? bus.mem_rdata : '0;
   assign bus.c2_rdata  = (resp[1] && !we_q[1]) ? bus.mem_rdata : '0;

endmodule
